// File: rtl/filter_3x3_seq_ctrl.sv
// Load/read sequencer for the 3-row x 240-px 3x3 filter RAM block.
// Optional macro FILT_CTRL_BORDER_EN: read cursors 0..ROW_LEN-1, with the border pixels forced to zero.
module filter_3x3_seq_ctrl #(
  parameter int BLOCK_LENGTH = 720,
  parameter int ROW_LEN      = 240,
  parameter int RD_LAT       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        f_wren,
  output logic [9:0]  f_cursor,
  output logic [15:0] f_din,
  input  logic [15:0] f_d_out,
  input  logic        f_d_rdy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a beat transfers on a rising clk edge where valid and ready are both high;
  // the upstream side may drop in_valid at any time, and out_valid/out_data/out_last hold until out_ready.

  typedef enum logic [2:0] {IDLE, LOAD, RD_SET, RD_WAIT, RD_OUT, DONE} state_t;

  localparam logic [9:0] WR_LAST  = 10'(BLOCK_LENGTH - 1);
  localparam logic [3:0] WAIT_MAX = 4'(RD_LAT);
`ifdef FILT_CTRL_BORDER_EN
  localparam logic [9:0] RD_FIRST = 10'd0;
  localparam logic [9:0] RD_LAST  = 10'(ROW_LEN - 1);
`else
  localparam logic [9:0] RD_FIRST = 10'd1;
  localparam logic [9:0] RD_LAST  = 10'(ROW_LEN - 2);
`endif

  state_t      state, state_n;
  logic [9:0]  wr_cnt, wr_cnt_n;
  logic [9:0]  rd_cnt, rd_cnt_n;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic [9:0]  cursor_q, cursor_n;
  logic        out_valid_q, out_valid_n;
  logic [15:0] out_data_q, out_data_n;
  logic        is_border;

`ifdef FILT_CTRL_BORDER_EN
  assign is_border = (rd_cnt == 10'd0) || (rd_cnt == RD_LAST);
`else
  assign is_border = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      cursor_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state       <= state_n;
      wr_cnt      <= wr_cnt_n;
      rd_cnt      <= rd_cnt_n;
      wait_cnt    <= wait_cnt_n;
      cursor_q    <= cursor_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_cnt_n    = wr_cnt;
    rd_cnt_n    = rd_cnt;
    wait_cnt_n  = wait_cnt;
    cursor_n    = cursor_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = LOAD;
          wr_cnt_n = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_cnt_n = wr_cnt + 10'd1;
          if (wr_cnt == WR_LAST) begin
            state_n  = RD_SET;
            rd_cnt_n = RD_FIRST;
          end
        end
      end
      RD_SET: begin
        cursor_n   = rd_cnt;
        wait_cnt_n = '0;
        if (is_border) begin
          out_data_n  = '0;
          out_valid_n = 1'b1;
          state_n     = RD_OUT;
        end else begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // d_rdy only counts once the RAM has had RD_LAT cycles to see the new cursor
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt_n = wait_cnt + 4'd1;
        end else if (f_d_rdy) begin
          out_data_n  = f_d_out;
          out_valid_n = 1'b1;
          state_n     = RD_OUT;
        end
      end
      RD_OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (rd_cnt == RD_LAST) begin
            state_n = DONE;
          end else begin
            rd_cnt_n = rd_cnt + 10'd1;
            state_n  = RD_SET;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == LOAD);
  assign f_wren    = (state == LOAD) && in_valid;
  assign f_din     = in_data;
  assign f_cursor  = (state == LOAD) ? wr_cnt : cursor_q;
  assign busy      = (state == LOAD) || (state == RD_SET) || (state == RD_WAIT) || (state == RD_OUT);
  assign done      = (state == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_valid_q && (rd_cnt == RD_LAST);
  assign dbg_state = state;

endmodule

// File: tb/tb_filter_3x3_seq_ctrl.sv
// Directed bench for filter_3x3_seq_ctrl with a small filter-RAM stand-in (d_out = RAM[cursor], 3-cycle latency).
module tb_filter_3x3_seq_ctrl;

  localparam int BLOCK_LENGTH = 720;
  localparam int ROW_LEN      = 240;
  localparam int RD_LAT       = 3;
`ifdef FILT_CTRL_BORDER_EN
  localparam bit BORDER   = 1'b1;
  localparam int RD_FIRST = 0;
  localparam int N_OUT    = ROW_LEN;
  localparam int FIRST_LAT = 1;
`else
  localparam bit BORDER   = 1'b0;
  localparam int RD_FIRST = 1;
  localparam int N_OUT    = ROW_LEN - 2;
  localparam int FIRST_LAT = RD_LAT + 2;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [15:0] in_data;
  logic        busy, done, in_ready, out_valid, out_last, f_wren, f_d_rdy;
  logic [15:0] out_data, f_din, f_d_out;
  logic [9:0]  f_cursor;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  filter_3x3_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .f_wren(f_wren), .f_cursor(f_cursor), .f_din(f_din), .f_d_out(f_d_out), .f_d_rdy(f_d_rdy),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // filter RAM stand-in: data and cursor both delayed 3 cycles; rdy when delayed cursor matches
  logic [15:0] mem [0:1023];
  logic [15:0] p1, p2, p3;
  logic [9:0]  c1 = '1, c2 = '1, c3 = '1;
  logic        force_rdy = 1'b0;
  always @(posedge clk) begin
    if (f_wren) mem[f_cursor] <= f_din;
    p1 <= mem[f_cursor];
    p2 <= p1;
    p3 <= p2;
    c1 <= f_cursor;
    c2 <= c1;
    c3 <= c2;
  end
  assign f_d_out = p3;
  assign f_d_rdy = force_rdy || (c3 == f_cursor);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One band: load 720 px, then collect outputs. stall_cur / rst_cur are cursor values (-1 = unused).
  task automatic run_band(input bit gaps, input int stall_cur, input bit frc, input int rst_cur);
    int wr, wren_cyc, bad_load, cyc, n, cur, lat, stall, bad_hold, bad_cur;
    bit first, aborted;
    logic [15:0] held, exp_d;
    force_rdy = frc;
    exp_q.delete();
    for (int c = RD_FIRST; c < RD_FIRST + N_OUT; c++)
      exp_q.push_back((BORDER && (c == 0 || c == ROW_LEN - 1)) ? 16'h0000 : 16'(c));

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", busy, 1);
    check("start_state", dbg_state, ST_LOAD);

    wr = 0; wren_cyc = 0; bad_load = 0; cyc = 0;
    while (wr < BLOCK_LENGTH && cyc < 4000) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data  = 16'(wr);
      start    = gaps && (cyc == 50);
      #1;
      if (f_wren) wren_cyc++;
      if (f_wren !== in_valid || f_cursor !== 10'(wr) || in_ready !== 1'b1 || out_valid !== 1'b0)
        bad_load++;
      if (in_valid) wr++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_wren_cycles", wren_cyc, BLOCK_LENGTH);
    check("load_bad_cycles", bad_load, 0);
    check("load_cycles", cyc, gaps ? 2 * BLOCK_LENGTH - 1 : BLOCK_LENGTH);

    n = 0; cyc = 0; lat = 0; stall = 0; bad_hold = 0; bad_cur = 0; first = 1'b1; aborted = 1'b0;
    held = '0;
    while (n < N_OUT && cyc < 20000 && !aborted) begin
      cur = RD_FIRST + n;
      if (out_valid) begin
        if (first) begin
          check("first_latency", lat, FIRST_LAT);
          first = 1'b0;
        end
        if (f_cursor !== 10'(cur)) bad_cur++;
        if (cur == rst_cur) begin
          reset = 1'b1;
          out_ready = 1'b0;
          @(negedge clk);
          check("rst_state", dbg_state, ST_IDLE);
          check("rst_out_valid", out_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          reset = 1'b0;
          out_ready = 1'b1;
          repeat (4) @(negedge clk);
          check("rst_no_done_after", done, 0);
          check("rst_idle_after", dbg_state, ST_IDLE);
          aborted = 1'b1;
        end else if (cur == stall_cur && stall < 10) begin
          if (stall == 0) held = out_data;
          else if (out_data !== held || out_last !== 1'b0) bad_hold++;
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          exp_d = exp_q.pop_front();
          check("out_data", out_data, exp_d);
          check("out_last", out_last, n == N_OUT - 1);
          n++;
        end
      end else begin
        out_ready = 1'b1;
        if (first) lat++;
      end
      cyc++;
      if (!aborted) @(negedge clk);
    end
    check("read_in_time", cyc < 20000, 1);
    if (!aborted) begin
      check("read_cursor_held", bad_cur, 0);
      check("out_count", n, N_OUT);
      if (stall_cur >= 0) begin
        check("stall_cycles", stall, 10);
        check("stall_hold", bad_hold, 0);
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_state", dbg_state, ST_DONE);
      @(negedge clk);
      check("after_done", done, 0);
      check("after_busy", busy, 0);
      check("after_state", dbg_state, ST_IDLE);
    end
    force_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_in_ready0", in_ready, 0);
    check("rst_out_valid0", out_valid, 0);
    check("rst_out_last0", out_last, 0);
    check("rst_f_wren0", f_wren, 0);
    check("rst_f_cursor0", f_cursor, 0);
    check("rst_out_data0", out_data, 0);
    check("rst_state0", dbg_state, ST_IDLE);

    run_band(1'b0, -1, 1'b0, -1);   // plain band
    run_band(1'b1, -1, 1'b0, -1);   // in_valid gaps, stray start during load
    run_band(1'b0,  5, 1'b0, -1);   // downstream stall on cursor 5
    run_band(1'b0, -1, 1'b1, -1);   // d_rdy stuck high
    run_band(1'b0, -1, 1'b0, 100);  // reset mid-read
    run_band(1'b0, -1, 1'b0, -1);   // clean band after abort

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_3x3_seq_ctrl.md
Name: filter_3x3_seq_ctrl

Overview:
Sequencer for the 3-row, 240-px 3x3 filter block (filter_3x3_720px).
- LOAD: streams one 720-pixel band (3 rows x 240 px, RGB565) from an upstream valid/ready source into the filter RAMs, driving cursor/wren/d_in.
- READ: steps the filter cursor through the middle-row pixels, waits out the 3-cycle RAM read latency and qualifies each result with d_rdy.
- Each filtered pixel is presented on a downstream valid/ready stream.
- Sits between the pixel source (SOPC/DMA side) and the frame writer.

Parameters:
BLOCK_LENGTH, 720, pixels written per band (cursor range 0..BLOCK_LENGTH-1).
ROW_LEN, 240, pixels per row; read cursor range 1..ROW_LEN-2.
RD_LAT, 3, minimum cycles from a read-cursor change to d_rdy qualification.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a band when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last output handshake
in_valid  in  1  upstream pixel valid
in_ready  out  1  upstream pixel accepted when in_valid & in_ready
in_data  in  16  upstream RGB565 pixel
out_valid  out  1  filtered pixel valid
out_ready  in  1  downstream accept
out_data  out  16  filtered RGB565 pixel
out_last  out  1  marks the final pixel of the band, qualified by out_valid
f_wren  out  1  filter wren
f_cursor  out  10  filter cursor
f_din  out  16  filter d_in
f_d_out  in  16  filter d_out
f_d_rdy  in  1  filter d_rdy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; f_cursor=0; busy, done, in_ready, out_valid, out_last, f_wren = 0; out_data=0. A reset mid-band aborts immediately, drops any pending out_valid, and does not pulse done.
- FSM states: IDLE, LOAD, RD_SET, RD_WAIT, RD_OUT, DONE.
- IDLE: start=1 -> LOAD, busy=1, wr_cnt=0. start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - f_wren = in_valid (combinational); f_din = in_data; f_cursor = wr_cnt.
  - On handshake, wr_cnt increments.
  - On the handshake with wr_cnt = BLOCK_LENGTH-1 -> RD_SET with rd_cnt=1.
  - in_valid gaps stall the load without writing.
- RD_SET: f_wren=0; f_cursor<=rd_cnt; wait_cnt<=0 -> RD_WAIT.
- RD_WAIT:
  - wait_cnt increments, saturating at RD_LAT.
  - When wait_cnt==RD_LAT and f_d_rdy=1: out_data<=f_d_out, out_valid<=1 -> RD_OUT.
  - f_d_rdy is ignored before RD_LAT cycles have elapsed, which guards against a stale cursor3 match.
- RD_OUT:
  - out_valid, out_data and out_last are held until out_ready.
  - On handshake: if rd_cnt==ROW_LEN-2 -> DONE; else rd_cnt++ -> RD_SET.
  - f_cursor is held stable throughout.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: out_valid rises RD_LAT+2 cycles after RD_SET is entered when f_d_rdy is already high. Throughput is at most 1 pixel per RD_LAT+3 cycles.
- out_last = out_valid & (rd_cnt==ROW_LEN-2).
- Band output count: ROW_LEN-2 = 238 pixels.
- in_ready is low outside LOAD. out_valid never asserts during LOAD.
- Counters: wr_cnt is 10 bits, rd_cnt is 10 bits. No wrap; each band restarts from 0 and 1.

Optional Feature:
Macro FILT_CTRL_BORDER_EN.
- Defined: the read phase covers cursor 0..ROW_LEN-1. Cursor 0 and ROW_LEN-1 skip RD_WAIT and emit out_data=16'h0000 directly. The band yields 240 outputs; out_last is on cursor 239.
- Undefined: only 1..238 are read, giving 238 outputs as above.

Test Plan:
1. Reset, then start. Stream 720 px with in_data=cursor index, in_valid always 1, out_ready=1 -> f_wren high 720 cycles with f_cursor 0..719; 238 outputs, out_data=q22 value (1..238); out_last on the 238th; done pulse; busy low after.
2. Same stream but in_valid toggles 1/0 -> f_wren low in gap cycles; wr_cnt advances only on handshakes; identical outputs.
3. out_ready held 0 for 10 cycles on pixel 5 -> out_valid and out_data stable; f_cursor stays 5; no skipped or duplicated pixels.
4. Force f_d_rdy=1 constantly -> first out_valid is still exactly RD_LAT+2 cycles after RD_SET entry, never earlier.
5. Assert reset during pixel 100 of the read phase -> next cycle: IDLE, out_valid=0, busy=0, no done. A new start then runs a clean band.
6. With FILT_CTRL_BORDER_EN defined -> 240 outputs; the first and last are 0x0000; out_last on the 240th.
